// File: rtl/conclover_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// conclover_mem_arbiter_pkg
// Shared definitions for the two-requester byte-memory arbiter:
//   - ADDR_W_DEF / DATA_W_DEF : default relative-address and data widths
//   - state_t                 : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package conclover_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conclover_rr_pick.sv
// ---------------------------------------------------------------------------
// conclover_rr_pick
// Combinational 2-way round-robin picker.
//   req[1:0] : pending requests
//   last     : index of the requester served most recently
//   grant    : index of the winner (meaningful only when valid=1)
//   valid    : at least one request pending
// A lone requester always wins; on a tie the one not served last wins.
// ---------------------------------------------------------------------------
module conclover_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    // With one request, req[1] is the index of that request.
    assign grant = (&req) ? ~last : req[1];

endmodule

// File: rtl/conclover_mem_arbiter.sv
// ---------------------------------------------------------------------------
// conclover_mem_arbiter
// Arbitrates two byte requesters onto a single memory-access unit.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_rd / reqN_wr        : requester N read / write, held until ackN
//   reqN_addr / reqN_wdata   : requester N relative byte address / write byte
//   ackN / rdataN            : one-cycle completion strobe / read byte
//   mem_rel_addr             : latched address to the memory-access unit
//   mem_read / mem_write     : one-cycle command pulses (ISSUE only)
//   mem_save_data            : latched write byte
//   mem_read_data / mem_rdy  : read byte and single-cycle completion
//   busy                     : high in every state except IDLE
//
// All outputs are registered. A request seen at edge T raises the command
// pulse during the following cycle; mem_rdy seen at an edge raises ack
// during the following cycle.
// ---------------------------------------------------------------------------
module conclover_mem_arbiter
    import conclover_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_rd,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1_rd,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_rel_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_save_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_rdy,

    output logic              busy
);

    // Requester inputs gathered into indexable arrays.
    logic [1:0]             req_any;
    logic [1:0]             req_wr;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;

    assign req_any   = {req1_rd | req1_wr, req0_rd | req0_wr};
    assign req_wr    = {req1_wr, req0_wr};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};

    state_t state;
    logic   last;      // most recently served requester
    logic   win_idx;   // requester owning the current transaction
    logic   pick_idx;
    logic   pick_vld;

    conclover_rr_pick u_pick (
        .req   (req_any),
        .last  (last),
        .grant (pick_idx),
        .valid (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last          <= 1'b1;     // requester 0 wins the first tie
            win_idx       <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            mem_rel_addr  <= '0;
            mem_save_data <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        win_idx       <= pick_idx;
                        mem_rel_addr  <= req_addr[pick_idx];
                        mem_save_data <= req_wdata[pick_idx];
                        // rd+wr together is a write; the read is dropped.
                        mem_write     <= req_wr[pick_idx];
                        mem_read      <= ~req_wr[pick_idx];
                        busy          <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // No timeout: the memory unit is trusted to answer.
                    if (mem_rdy) begin
                        if (win_idx) rdata1 <= mem_read_data;
                        else         rdata0 <= mem_read_data;
                        ack0  <= ~win_idx;
                        ack1  <= win_idx;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    last  <= win_idx;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
